// File: rtl/reg_pipe.sv
// reg_pipe: WIDTH-bit, STAGES-deep valid/ready register pipeline with bubble collapse,
// synchronous flush and a registered occupancy count.
module reg_pipe #(
  parameter int WIDTH = 8,
  parameter int STAGES = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic in_ready,
  output logic out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic out_ready,
  output logic [$clog2(STAGES+1)-1:0] count
);
  localparam int CW = $clog2(STAGES + 1);
  logic [STAGES-1:0] r_v, w_rdy, w_up_v;
  logic [STAGES-1:0][WIDTH-1:0] r_d, w_up_d;
  logic [CW-1:0] r_count;
  logic w_acc, w_con;
  // A stage can load when it is empty or its occupant moves on this edge.
  always_comb begin
    w_rdy[STAGES-1] = !r_v[STAGES-1] | out_ready;
    for (int i = STAGES - 2; i >= 0; i--) w_rdy[i] = !r_v[i] | w_rdy[i+1];
  end
  always_comb begin
    w_up_v[0] = in_valid;
    w_up_d[0] = in_data;
    for (int i = 1; i < STAGES; i++) begin
      w_up_v[i] = r_v[i-1];
      w_up_d[i] = r_d[i-1];
    end
  end
  assign in_ready  = w_rdy[0] & !flush;
  assign w_acc     = in_valid & in_ready;
  assign w_con     = r_v[STAGES-1] & out_ready;
  assign out_valid = r_v[STAGES-1];
  assign out_data  = r_d[STAGES-1];
  assign count     = r_count;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
      r_d <= {STAGES{RESET_VAL}};
      r_count <= '0;
    end else if (flush) begin
      r_v <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (w_rdy[i]) r_v[i] <= w_up_v[i];
        if (w_rdy[i] && w_up_v[i]) r_d[i] <= w_up_d[i];
      end
      r_count <= r_count + CW'(w_acc) - CW'(w_con);
    end
  end
endmodule

// File: tb/tb_reg_pipe.sv
// tb_reg_pipe: directed vectors plus randomized traffic for reg_pipe (8-bit x 4 and 1-bit x 1),
// compared against a queue model where a word shows up STAGES-1 edges after acceptance at the earliest.
module tb_reg_pipe;
  logic clk = 0, rst_n = 0;
  logic a_fl, a_iv, a_ordy, a_ir, a_ov;
  logic [7:0] a_id, a_od;
  logic [2:0] a_cnt;
  logic b_fl, b_iv, b_ordy, b_ir, b_ov;
  logic [0:0] b_id, b_od, b_cnt;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  reg_pipe #(.WIDTH(8), .STAGES(4)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(a_fl), .in_valid(a_iv), .in_data(a_id), .in_ready(a_ir),
    .out_valid(a_ov), .out_data(a_od), .out_ready(a_ordy), .count(a_cnt));
  reg_pipe #(.WIDTH(1), .STAGES(1)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(b_fl), .in_valid(b_iv), .in_data(b_id), .in_ready(b_ir),
    .out_valid(b_ov), .out_data(b_od), .out_ready(b_ordy), .count(b_cnt));

  typedef struct {
    logic fl, iv;
    logic [7:0] id;
    logic ordy, eir, eov;
    logic [7:0] eod;
    int ecnt;
  } vec_t;

  int st[2] = '{4, 1};
  logic [31:0] md[2][8];
  int mt[2][8];
  int mh[2], mn[2];
  logic [31:0] mlast[2];
  int edge_n = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic mreset();
    for (int k = 0; k < 2; k++) begin
      mh[k] = 0;
      mn[k] = 0;
      mlast[k] = 0;
    end
  endtask

  function automatic vec_t mk(input logic fl, iv, input logic [7:0] id, input logic ordy, eir, eov,
                              input logic [7:0] eod, input int ecnt);
    return '{fl, iv, id, ordy, eir, eov, eod, ecnt};
  endfunction

  // Checks both DUTs against the model for the current cycle, then advances one edge.
  task automatic tick();
    logic [31:0] ir[2], ov[2], od[2], cn[2], id[2];
    logic fl[2], iv[2], rd[2];
    #1;
    ir = '{a_ir, b_ir};
    ov = '{a_ov, b_ov};
    od = '{a_od, b_od};
    cn = '{a_cnt, b_cnt};
    id = '{a_id, b_id};
    fl = '{a_fl, b_fl};
    iv = '{a_iv, b_iv};
    rd = '{a_ordy, b_ordy};
    for (int k = 0; k < 2; k++) begin
      string p;
      bit vis, eir;
      int slot;
      p = k ? "B_" : "A_";
      vis = mn[k] > 0 && (edge_n - mt[k][mh[k]]) >= st[k] - 1;
      eir = !fl[k] && (mn[k] < st[k] || rd[k]);
      if (vis) mlast[k] = md[k][mh[k]];
      chk({p, "in_ready"}, ir[k], 32'(eir));
      chk({p, "out_valid"}, ov[k], 32'(vis));
      chk({p, "out_data"}, od[k], mlast[k]);
      chk({p, "count"}, cn[k], mn[k]);
      if (fl[k]) mn[k] = 0;
      else begin
        if (vis && rd[k]) begin
          mh[k] = (mh[k] + 1) % 8;
          mn[k]--;
        end
        if (iv[k] && eir) begin
          slot = (mh[k] + mn[k]) % 8;
          md[k][slot] = id[k];
          mt[k][slot] = edge_n + 1;
          mn[k]++;
        end
      end
    end
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  initial begin
    vec_t tv[$];
    {a_fl, a_iv, a_ordy, a_id} = '0;
    {b_fl, b_iv, b_id} = '0;
    b_ordy = 1;
    mreset();
    #1;
    chk("rst_A_out_valid", a_ov, 0);
    chk("rst_A_out_data", a_od, 0);
    chk("rst_A_count", a_cnt, 0);
    chk("rst_A_in_ready", a_ir, 1);
    chk("rst_B_out_valid", b_ov, 0);
    chk("rst_B_count", b_cnt, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    // streaming 0x01..0x10 with out_ready held high
    for (int i = 0; i < 21; i++)
      tv.push_back(mk(0, i < 16, 8'(i + 1), 1, 1, i >= 4 && i < 20,
                      8'(i < 4 ? 0 : (i < 20 ? i - 3 : 16)), i < 4 ? i : (i < 16 ? 4 : 20 - i)));
    // fill under backpressure, then accept and consume on the same edge
    tv.push_back(mk(0, 1, 8'hA0, 0, 1, 0, 8'h10, 0));
    tv.push_back(mk(0, 1, 8'hA1, 0, 1, 0, 8'h10, 1));
    tv.push_back(mk(0, 1, 8'hA2, 0, 1, 0, 8'h10, 2));
    tv.push_back(mk(0, 1, 8'hA3, 0, 1, 0, 8'h10, 3));
    tv.push_back(mk(0, 1, 8'hA4, 0, 0, 1, 8'hA0, 4));
    tv.push_back(mk(0, 1, 8'hA4, 0, 0, 1, 8'hA0, 4));
    tv.push_back(mk(0, 1, 8'hA4, 1, 1, 1, 8'hA0, 4));
    tv.push_back(mk(0, 1, 8'hA5, 0, 0, 1, 8'hA1, 4));
    tv.push_back(mk(0, 0, 8'h00, 1, 1, 1, 8'hA1, 4));
    tv.push_back(mk(0, 0, 8'h00, 1, 1, 1, 8'hA2, 3));
    tv.push_back(mk(0, 0, 8'h00, 1, 1, 1, 8'hA3, 2));
    tv.push_back(mk(0, 0, 8'h00, 1, 1, 1, 8'hA4, 1));
    tv.push_back(mk(0, 0, 8'h00, 1, 1, 0, 8'hA4, 0));
    // bubble collapse
    tv.push_back(mk(0, 1, 8'h11, 0, 1, 0, 8'hA4, 0));
    tv.push_back(mk(0, 0, 8'h00, 0, 1, 0, 8'hA4, 1));
    tv.push_back(mk(0, 0, 8'h00, 0, 1, 0, 8'hA4, 1));
    tv.push_back(mk(0, 1, 8'h22, 0, 1, 0, 8'hA4, 1));
    tv.push_back(mk(0, 0, 8'h00, 0, 1, 1, 8'h11, 2));
    tv.push_back(mk(0, 0, 8'h00, 0, 1, 1, 8'h11, 2));
    tv.push_back(mk(0, 0, 8'h00, 0, 1, 1, 8'h11, 2));
    tv.push_back(mk(0, 0, 8'h00, 1, 1, 1, 8'h11, 2));
    tv.push_back(mk(0, 0, 8'h00, 1, 1, 1, 8'h22, 1));
    tv.push_back(mk(0, 0, 8'h00, 1, 1, 0, 8'h22, 0));
    // flush with a word offered in the same cycle
    tv.push_back(mk(0, 1, 8'h31, 0, 1, 0, 8'h22, 0));
    tv.push_back(mk(0, 1, 8'h32, 0, 1, 0, 8'h22, 1));
    tv.push_back(mk(0, 1, 8'h33, 0, 1, 0, 8'h22, 2));
    tv.push_back(mk(1, 1, 8'h34, 0, 0, 0, 8'h22, 3));
    tv.push_back(mk(0, 0, 8'h00, 0, 1, 0, 8'h22, 0));
    tv.push_back(mk(0, 1, 8'h41, 1, 1, 0, 8'h22, 0));
    tv.push_back(mk(0, 0, 8'h00, 1, 1, 0, 8'h22, 1));
    tv.push_back(mk(0, 0, 8'h00, 1, 1, 0, 8'h22, 1));
    tv.push_back(mk(0, 0, 8'h00, 1, 1, 0, 8'h22, 1));
    tv.push_back(mk(0, 0, 8'h00, 1, 1, 1, 8'h41, 1));
    tv.push_back(mk(0, 0, 8'h00, 1, 1, 0, 8'h41, 0));
    foreach (tv[i]) begin
      a_fl = tv[i].fl;
      a_iv = tv[i].iv;
      a_id = tv[i].id;
      a_ordy = tv[i].ordy;
      #1;
      chk($sformatf("vec%0d_in_ready", i), a_ir, tv[i].eir);
      chk($sformatf("vec%0d_out_valid", i), a_ov, tv[i].eov);
      chk($sformatf("vec%0d_out_data", i), a_od, tv[i].eod);
      chk($sformatf("vec%0d_count", i), a_cnt, tv[i].ecnt);
      tick();
    end
    // randomized traffic on both configurations
    for (int c = 0; c < 1000; c++) begin
      a_iv = 1'($urandom_range(0, 1));
      a_id = 8'($urandom);
      a_ordy = $urandom_range(0, 3) != 0;
      a_fl = $urandom_range(0, 31) == 0;
      b_iv = 1'($urandom_range(0, 1));
      b_id = 1'($urandom);
      b_ordy = 1'($urandom_range(0, 1));
      tick();
    end
    // asynchronous reset mid-stream
    a_fl = 0;
    a_iv = 1;
    a_ordy = 0;
    #2;
    rst_n = 0;
    #1;
    chk("midrst_A_out_valid", a_ov, 0);
    chk("midrst_A_out_data", a_od, 0);
    chk("midrst_A_count", a_cnt, 0);
    chk("midrst_A_in_ready", a_ir, 1);
    chk("midrst_B_out_valid", b_ov, 0);
    chk("midrst_B_out_data", b_od, 0);
    chk("midrst_B_count", b_cnt, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1;
    mreset();
    a_iv = 0;
    b_iv = 0;
    tick();
    a_iv = 1;
    a_id = 8'h5A;
    a_ordy = 1;
    tick();
    a_iv = 0;
    for (int c = 0; c < 5; c++) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
